// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared types and default latencies for the FPR common data bus arbiter.
package fpr_cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 6;
  localparam int CDB_DATA_W = 32;

  // Default execution-unit latencies, dispatch to result-valid.
  localparam int DEF_FADD_LAT  = 3;
  localparam int DEF_FMUL_LAT  = 2;
  localparam int DEF_FDIV_LAT  = 11;
  localparam int DEF_FSQRT_LAT = 15;
  localparam int DEF_DEPTH     = 16;

  // Owner of one future CDB cycle.
  typedef enum logic [2:0] {
    OWN_NONE  = 3'd0,
    OWN_FADD  = 3'd1,
    OWN_FMUL  = 3'd2,
    OWN_FDIV  = 3'd3,
    OWN_FSQRT = 3'd4
  } cdb_owner_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/fpr_cdb_sched.sv
// Slot schedule: own[k] names the unit that writes the CDB k cycles from now.
// Shifts one slot per cycle and accepts up to three reservations per cycle.
module fpr_cdb_sched
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx [3],
  input  cdb_owner_t       i_wr_own [3],
  output cdb_owner_t       o_own    [DEPTH]
);

  cdb_owner_t r_own [DEPTH];

  // Advance the schedule by one slot, then record this cycle's grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_own[k] <= OWN_NONE;
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) r_own[k] <= r_own[k+1];
      r_own[DEPTH-1] <= OWN_NONE;
      for (int w = 0; w < 3; w++) begin
        if (i_wr_en[w]) r_own[i_wr_idx[w]] <= i_wr_own[w];
      end
    end
  end

  assign o_own = r_own;

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FPR CDB arbiter: grants FP unit dispatch only when the CDB slot at
// (now + unit latency) is free, then muxes the owning unit onto the CDB
// in that slot. Priority: fdiv/fsqrt, then fmul, then fadd.
module fpr_cdb_arbiter
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int FADD_LAT  = DEF_FADD_LAT,
  parameter int FMUL_LAT  = DEF_FMUL_LAT,
  parameter int FDIV_LAT  = DEF_FDIV_LAT,
  parameter int FSQRT_LAT = DEF_FSQRT_LAT,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fadd_req_valid,
  output logic o_fadd_req_ready,
  input  logic i_fmul_req_valid,
  output logic o_fmul_req_ready,
  input  logic i_fdiv_fsqrt_req_valid,
  output logic o_fdiv_fsqrt_req_ready,
  input  logic i_fdiv_fsqrt_req_is_fsqrt,
  input  cdb_t i_result_fadd,
  input  cdb_t i_result_fmul,
  input  cdb_t i_result_fdiv,
  input  cdb_t i_result_fsqrt,
  output cdb_t o_fpr_cdb
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] L_FADD  = IDX_W'(FADD_LAT);
  localparam logic [IDX_W-1:0] L_FMUL  = IDX_W'(FMUL_LAT);
  localparam logic [IDX_W-1:0] L_FDIV  = IDX_W'(FDIV_LAT);
  localparam logic [IDX_W-1:0] L_FSQRT = IDX_W'(FSQRT_LAT);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  cdb_owner_t       w_own    [DEPTH];
  logic [IDX_W-1:0] w_wr_idx [3];
  cdb_owner_t       w_wr_own [3];
  logic [2:0]       w_wr_en;
  logic [IDX_W-1:0] w_lat_ds;
  cdb_owner_t       w_own_ds;
  logic             w_rdy_ds;
  logic             w_rdy_fmul;
  logic             w_rdy_fadd;
  cdb_t             w_cdb;

  // Effective latency and owner code of the fdiv/fsqrt station.
  always_comb begin
    w_lat_ds = i_fdiv_fsqrt_req_is_fsqrt ? L_FSQRT : L_FDIV;
    w_own_ds = i_fdiv_fsqrt_req_is_fsqrt ? OWN_FSQRT : OWN_FDIV;
  end

  // Ready per requester, judged on the pre-shift schedule; lower priority
  // yields to a valid higher-priority requester aiming at the same slot.
  always_comb begin
    w_rdy_ds   = !reset && (w_own[w_lat_ds] == OWN_NONE);
    w_rdy_fmul = !reset && (w_own[L_FMUL] == OWN_NONE)
                 && !(i_fdiv_fsqrt_req_valid && (w_lat_ds == L_FMUL));
    w_rdy_fadd = !reset && (w_own[L_FADD] == OWN_NONE)
                 && !(i_fdiv_fsqrt_req_valid && (w_lat_ds == L_FADD))
                 && !(i_fmul_req_valid && (L_FMUL == L_FADD));
  end

  // Reservation writes land at L-1 because the schedule shifts in the same edge.
  always_comb begin
    w_wr_en[0]  = i_fdiv_fsqrt_req_valid && w_rdy_ds;
    w_wr_idx[0] = w_lat_ds - ONE;
    w_wr_own[0] = w_own_ds;
    w_wr_en[1]  = i_fmul_req_valid && w_rdy_fmul;
    w_wr_idx[1] = L_FMUL - ONE;
    w_wr_own[1] = OWN_FMUL;
    w_wr_en[2]  = i_fadd_req_valid && w_rdy_fadd;
    w_wr_idx[2] = L_FADD - ONE;
    w_wr_own[2] = OWN_FADD;
  end

  fpr_cdb_sched #(.DEPTH(DEPTH)) u_sched (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_wr_idx),
    .i_wr_own (w_wr_own),
    .o_own    (w_own)
  );

  // Broadcast the current slot owner's result; unit valid bits are not trusted.
  always_comb begin
    case (w_own[0])
      OWN_FADD:  w_cdb = i_result_fadd;
      OWN_FMUL:  w_cdb = i_result_fmul;
      OWN_FDIV:  w_cdb = i_result_fdiv;
      OWN_FSQRT: w_cdb = i_result_fsqrt;
      default:   w_cdb = '0;
    endcase
    w_cdb.valid = !reset && (w_own[0] != OWN_NONE);
  end

  assign o_fadd_req_ready       = w_rdy_fadd;
  assign o_fmul_req_ready       = w_rdy_fmul;
  assign o_fdiv_fsqrt_req_ready = w_rdy_ds;
  assign o_fpr_cdb              = w_cdb;

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Directed bench for fpr_cdb_arbiter: default-latency instance plus an
// instance with FDIV_LAT=3 for the same-cycle collision case.
module tb_fpr_cdb_arbiter;
  import fpr_cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fadd_v = 1'b0, fmul_v = 1'b0, ds_v = 1'b0, is_fsqrt = 1'b0;
  cdb_t res_fadd, res_fmul, res_fdiv, res_fsqrt;
  logic rdy_fadd, rdy_fmul, rdy_ds, rdy3_fadd, rdy3_fmul, rdy3_ds;
  cdb_t cdb, cdb3;
  int n_chk = 0;
  int n_err = 0;
  logic [ROB_WIDTH-1:0] exp_q [$];
  logic [ROB_WIDTH-1:0] exp_tag;

  always #5 clk = ~clk;

  fpr_cdb_arbiter u_dut (
    .clk(clk), .reset(reset),
    .i_fadd_req_valid(fadd_v), .o_fadd_req_ready(rdy_fadd),
    .i_fmul_req_valid(fmul_v), .o_fmul_req_ready(rdy_fmul),
    .i_fdiv_fsqrt_req_valid(ds_v), .o_fdiv_fsqrt_req_ready(rdy_ds),
    .i_fdiv_fsqrt_req_is_fsqrt(is_fsqrt),
    .i_result_fadd(res_fadd), .i_result_fmul(res_fmul),
    .i_result_fdiv(res_fdiv), .i_result_fsqrt(res_fsqrt),
    .o_fpr_cdb(cdb)
  );

  fpr_cdb_arbiter #(.FDIV_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_fadd_req_valid(fadd_v), .o_fadd_req_ready(rdy3_fadd),
    .i_fmul_req_valid(fmul_v), .o_fmul_req_ready(rdy3_fmul),
    .i_fdiv_fsqrt_req_valid(ds_v), .o_fdiv_fsqrt_req_ready(rdy3_ds),
    .i_fdiv_fsqrt_req_is_fsqrt(is_fsqrt),
    .i_result_fadd(res_fadd), .i_result_fmul(res_fmul),
    .i_result_fdiv(res_fdiv), .i_result_fsqrt(res_fsqrt),
    .o_fpr_cdb(cdb3)
  );

  function automatic cdb_t mk(input logic v, input int tag, input logic [31:0] d);
    cdb_t c;
    c.valid = v;
    c.tag   = ROB_WIDTH'(tag);
    c.data  = d;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fadd_v = 1'b0; fmul_v = 1'b0; ds_v = 1'b0; is_fsqrt = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    res_fadd  = mk(1'b0, 5, 32'h3f800000);
    res_fmul  = mk(1'b0, 3, 32'h40400000);
    res_fdiv  = mk(1'b0, 7, 32'h40a00000);
    res_fsqrt = mk(1'b0, 9, 32'h41100000);

    // Reset held: readies and CDB valid forced low.
    cyc();
    #1;
    chk("rst_ready", {rdy_fadd, rdy_fmul, rdy_ds}, 3'b000);
    chk("rst_cdb_valid", cdb.valid, 1'b0);
    cyc();
    reset = 1'b0;

    // Idle 20 cycles.
    for (int k = 0; k < 20; k++) begin
      cyc();
      #1;
      chk("idle_valid", cdb.valid, 1'b0);
      if (k == 0) chk("idle_ready", {rdy_fadd, rdy_fmul, rdy_ds}, 3'b111);
    end

    // Single fmul: granted at A, broadcast at A+2 only.
    cyc();
    fmul_v = 1'b1;
    #1;
    chk("fmul_ready", rdy_fmul, 1'b1);
    chk("fmul_fadd_ready", rdy_fadd, 1'b1);
    cyc();
    fmul_v = 1'b0;
    #1;
    chk("fmul_t1_valid", cdb.valid, 1'b0);
    cyc();
    #1;
    chk("fmul_t2_cdb", cdb, mk(1'b1, 3, 32'h40400000));
    cyc();
    #1;
    chk("fmul_t3_valid", cdb.valid, 1'b0);

    // Same-slot conflict: fadd at B, fmul at B+1 targets the same slot.
    do_reset();
    res_fadd = mk(1'b0, 5, 32'h11111111);
    res_fmul = mk(1'b0, 6, 32'h22222222);
    cyc();
    fadd_v = 1'b1;
    #1;
    chk("conf_fadd_ready", rdy_fadd, 1'b1);
    cyc();
    fadd_v = 1'b0;
    fmul_v = 1'b1;
    #1;
    chk("conf_fmul_blocked", rdy_fmul, 1'b0);
    cyc();
    #1;
    chk("conf_fmul_ready", rdy_fmul, 1'b1);
    cyc();
    fmul_v = 1'b0;
    #1;
    chk("conf_b3_cdb", cdb, mk(1'b1, 5, 32'h11111111));
    cyc();
    #1;
    chk("conf_b4_cdb", cdb, mk(1'b1, 6, 32'h22222222));
    cyc();
    #1;
    chk("conf_b5_valid", cdb.valid, 1'b0);

    // Same-cycle collision on the FDIV_LAT=3 instance.
    do_reset();
    res_fdiv = mk(1'b0, 7, 32'h33333333);
    res_fadd = mk(1'b0, 8, 32'h44444444);
    cyc();
    ds_v = 1'b1;
    fadd_v = 1'b1;
    #1;
    chk("coll_ds_ready", rdy3_ds, 1'b1);
    chk("coll_fadd_blocked", rdy3_fadd, 1'b0);
    chk("coll_fadd_ready_deflat", rdy_fadd, 1'b1);
    cyc();
    ds_v = 1'b0;
    #1;
    chk("coll_fadd_ready", rdy3_fadd, 1'b1);
    cyc();
    fadd_v = 1'b0;
    #1;
    chk("coll_c2_valid", cdb3.valid, 1'b0);
    cyc();
    #1;
    chk("coll_c3_cdb", cdb3, mk(1'b1, 7, 32'h33333333));
    cyc();
    #1;
    chk("coll_c4_cdb", cdb3, mk(1'b1, 8, 32'h44444444));
    cyc();
    #1;
    chk("coll_c5_valid", cdb3.valid, 1'b0);

    // Mixed latencies: fsqrt at D lands D+15; fadd blocked at D+12, lands D+16.
    do_reset();
    res_fsqrt = mk(1'b0, 9, 32'h55555555);
    res_fadd  = mk(1'b0, 10, 32'h66666666);
    exp_q.push_back(ROB_WIDTH'(9));
    exp_q.push_back(ROB_WIDTH'(10));
    cyc();
    is_fsqrt = 1'b1;
    ds_v = 1'b1;
    #1;
    chk("mix_sqrt_ready", rdy_ds, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      ds_v = 1'b0;
      fadd_v = (k == 12) || (k == 13);
      #1;
      if (k == 12) chk("mix_fadd_blocked", rdy_fadd, 1'b0);
      if (k == 13) chk("mix_fadd_ready", rdy_fadd, 1'b1);
      chk("mix_valid", cdb.valid, (k == 15) || (k == 16));
      if (cdb.valid) begin
        exp_tag = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk("mix_tag_order", cdb.tag, exp_tag);
      end
    end
    chk("mix_all_seen", exp_q.size(), 0);
    fadd_v = 1'b0;
    is_fsqrt = 1'b0;

    // Reset mid-flight: fdiv at E would land E+11 but reset at E+5 drops it.
    do_reset();
    cyc();
    ds_v = 1'b1;
    #1;
    chk("rmf_ds_ready", rdy_ds, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      ds_v = 1'b0;
      reset = (k == 5);
      #1;
      if (k == 5) chk("rmf_rst_ready", {rdy_fadd, rdy_fmul, rdy_ds}, 3'b000);
      chk("rmf_valid", cdb.valid, 1'b0);
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
